// File: rtl/count_arbiter.sv
// count_arbiter
// ---------------------------------------------------------------------------
// Round-robin scheduler sharing one up-counter among NUM_REQ requesters.
// A requester raises req and presents a length on its len slice. The winner
// is granted, its length latched, and the shared counter runs 0..len_q. A
// single-cycle done pulse then marks completion for that requester.
//
// Parameters:
//   NUM_REQ  number of requesters (2..8)
//   CNT_W    counter / length width in bits
//
// Ports:
//   clk    in   rising-edge clock
//   rst    in   synchronous, active-high reset (dominates all inputs)
//   req    in   [NUM_REQ]        per-requester level request
//   len    in   [NUM_REQ*CNT_W]  packed lengths, requester i at [i*CNT_W +: CNT_W]
//   grant  out  [NUM_REQ]        registered one-hot grant, zero when no owner
//   count  out  [CNT_W]          registered shared counter value
//   busy   out                   high whenever the FSM is not idle
//   done   out  [NUM_REQ]        registered one-hot single-cycle completion pulse
//
// Build option:
//   COUNT_ARB_ABORT_EN  when defined, the granted requester dropping its req
//                       during a run abandons the run (no done pulse).
// ---------------------------------------------------------------------------
module count_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*CNT_W-1:0] len,
    output logic [NUM_REQ-1:0]       grant,
    output logic [CNT_W-1:0]         count,
    output logic                     busy,
    output logic [NUM_REQ-1:0]       done
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PTR_W-1:0] LAST = PTR_W'(NUM_REQ - 1);
    localparam logic [PTR_W:0]   NREQ = NUM_REQ[PTR_W:0];

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t             state;
    logic [PTR_W-1:0]   ptr;
    logic [CNT_W-1:0]   len_q;

    // Winner selection: rotate req so the pointer position lands at bit 0,
    // find the lowest set bit, then rotate the offset back.
    logic [2*NUM_REQ-1:0] req_dbl;
    logic [NUM_REQ-1:0]   rot;
    logic [PTR_W-1:0]     off;
    logic [PTR_W:0]       sum;
    logic [PTR_W:0]       diff;
    logic [PTR_W-1:0]     win;
    logic [PTR_W-1:0]     ptr_nxt;
    logic [CNT_W-1:0]     win_len;
    logic [NUM_REQ-1:0]   win_onehot;
    logic                 owner_drop;

    assign req_dbl = {req, req} >> ptr;
    assign rot     = req_dbl[NUM_REQ-1:0];

    always_comb begin
        off = '0;
        // Scan downward so the lowest set bit (closest to the pointer) wins.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                off = PTR_W'(k);
            end
        end
    end

    assign sum  = {1'b0, ptr} + {1'b0, off};
    assign diff = sum - NREQ;
    assign win  = (sum >= NREQ) ? diff[PTR_W-1:0] : sum[PTR_W-1:0];

    assign ptr_nxt = (win == LAST) ? '0 : win + 1'b1;

    always_comb begin
        win_len    = '0;
        win_onehot = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (win == PTR_W'(k)) begin
                win_len       = len[k*CNT_W +: CNT_W];
                win_onehot[k] = 1'b1;
            end
        end
    end

    // The current owner has released its request (only acted upon when the
    // abort option is built in).
    assign owner_drop = ((req & grant) == '0);

    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            grant <= '0;
            done  <= '0;
            count <= '0;
            ptr   <= '0;
            len_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done  <= '0;
                    count <= '0;
                    grant <= '0;
                    if (req != '0) begin
                        grant <= win_onehot;
                        len_q <= win_len;
                        ptr   <= ptr_nxt;
                        state <= ST_RUN;
                    end
                end

                ST_RUN: begin
`ifdef COUNT_ARB_ABORT_EN
                    // Abort outranks the terminal-count check on the same edge.
                    if (owner_drop) begin
                        state <= ST_IDLE;
                        grant <= '0;
                        count <= '0;
                    end else if (count == len_q) begin
                        state <= ST_DONE;
                        done  <= grant;
                        grant <= '0;
                    end else begin
                        count <= count + 1'b1;
                    end
`else
                    if (count == len_q) begin
                        state <= ST_DONE;
                        done  <= grant;
                        grant <= '0;
                    end else begin
                        count <= count + 1'b1;
                    end
`endif
                end

                ST_DONE: begin
                    done  <= '0;
                    grant <= '0;
                    count <= '0;
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                    grant <= '0;
                    done  <= '0;
                    count <= '0;
                end
            endcase
        end
    end

`ifndef COUNT_ARB_ABORT_EN
    // owner_drop only steers the abort path; keep it referenced otherwise.
    logic unused_owner_drop;
    assign unused_owner_drop = owner_drop;
`endif

endmodule

// File: tb/tb_count_arbiter.sv
// Testbench for count_arbiter (NUM_REQ=4, CNT_W=3). Directed stimulus pushes
// the expected registered outputs for each clock edge into a queue; a
// separate monitor pops one entry after every edge and compares.
module tb_count_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = 4'b0000;
    logic [11:0] len = 12'h000;
    logic [3:0]  grant;
    logic [2:0]  count;
    logic        busy;
    logic [3:0]  done;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        string      nm;
        logic [3:0] g;
        logic [3:0] d;
        logic [2:0] c;
        logic       b;
    } exp_t;

    exp_t sb[$];

    count_arbiter #(.NUM_REQ(4), .CNT_W(3)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .len   (len),
        .grant (grant),
        .count (count),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    // Drive inputs for the next edge and record what the outputs must be after it.
    task automatic cyc(input logic r, input logic [3:0] rq, input logic [11:0] ln,
                       input logic [3:0] g, input logic [3:0] d, input logic [2:0] c,
                       input logic b, input string nm);
        exp_t e;
        @(negedge clk);
        rst = r;
        req = rq;
        len = ln;
        e.nm = nm; e.g = g; e.d = d; e.c = c; e.b = b;
        sb.push_back(e);
    endtask

    // Monitor: one expectation per edge while stimulus is pending.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_cmp++;
                if (grant !== e.g) begin
                    n_bad++;
                    $display("FAIL %s grant: got %b expected %b", e.nm, grant, e.g);
                end
                n_cmp++;
                if (done !== e.d) begin
                    n_bad++;
                    $display("FAIL %s done: got %b expected %b", e.nm, done, e.d);
                end
                n_cmp++;
                if (count !== e.c) begin
                    n_bad++;
                    $display("FAIL %s count: got %0d expected %0d", e.nm, count, e.c);
                end
                n_cmp++;
                if (busy !== e.b) begin
                    n_bad++;
                    $display("FAIL %s busy: got %b expected %b", e.nm, busy, e.b);
                end
            end
        end
    end

    // Watchdog: the directed sequence is a few hundred cycles at most.
    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset held with all requests up.
        cyc(1, 4'b1111, 12'h000, 4'b0000, 4'b0000, 3'd0, 1'b0, "rst0");
        cyc(1, 4'b1111, 12'h000, 4'b0000, 4'b0000, 3'd0, 1'b0, "rst1");

        // Round-robin, all lengths zero: grant, done, idle per requester.
        cyc(0, 4'b1111, 12'h000, 4'b0001, 4'b0000, 3'd0, 1'b1, "rst_first_grant");
        cyc(0, 4'b1111, 12'h000, 4'b0000, 4'b0001, 3'd0, 1'b1, "rr_done0");
        cyc(0, 4'b1111, 12'h000, 4'b0000, 4'b0000, 3'd0, 1'b0, "rr_idle0");
        cyc(0, 4'b1111, 12'h000, 4'b0010, 4'b0000, 3'd0, 1'b1, "rr_grant1");
        cyc(0, 4'b1111, 12'h000, 4'b0000, 4'b0010, 3'd0, 1'b1, "rr_done1");
        cyc(0, 4'b1111, 12'h000, 4'b0000, 4'b0000, 3'd0, 1'b0, "rr_idle1");
        cyc(0, 4'b1111, 12'h000, 4'b0100, 4'b0000, 3'd0, 1'b1, "rr_grant2");
        cyc(0, 4'b1111, 12'h000, 4'b0000, 4'b0100, 3'd0, 1'b1, "rr_done2");
        cyc(0, 4'b1111, 12'h000, 4'b0000, 4'b0000, 3'd0, 1'b0, "rr_idle2");
        cyc(0, 4'b1111, 12'h000, 4'b1000, 4'b0000, 3'd0, 1'b1, "rr_grant3");
        cyc(0, 4'b1111, 12'h000, 4'b0000, 4'b1000, 3'd0, 1'b1, "rr_done3");
        cyc(0, 4'b1111, 12'h000, 4'b0000, 4'b0000, 3'd0, 1'b0, "rr_idle3");
        cyc(0, 4'b1111, 12'h000, 4'b0001, 4'b0000, 3'd0, 1'b1, "rr_wrap_grant0");
        cyc(0, 4'b1111, 12'h000, 4'b0000, 4'b0001, 3'd0, 1'b1, "rr_wrap_done0");
        cyc(0, 4'b0000, 12'h000, 4'b0000, 4'b0000, 3'd0, 1'b0, "rr_wrap_idle");
        cyc(0, 4'b0000, 12'h000, 4'b0000, 4'b0000, 3'd0, 1'b0, "idle_noreq");

        // Single request, requester 2, len=3 (pointer now 1).
        cyc(0, 4'b0100, 12'h0C0, 4'b0100, 4'b0000, 3'd0, 1'b1, "single_c0");
        cyc(0, 4'b0100, 12'h0C0, 4'b0100, 4'b0000, 3'd1, 1'b1, "single_c1");
        cyc(0, 4'b0100, 12'h0C0, 4'b0100, 4'b0000, 3'd2, 1'b1, "single_c2");
        cyc(0, 4'b0100, 12'h0C0, 4'b0100, 4'b0000, 3'd3, 1'b1, "single_c3");
        cyc(0, 4'b0100, 12'h0C0, 4'b0000, 4'b0100, 3'd3, 1'b1, "single_done");
        cyc(0, 4'b0000, 12'h0C0, 4'b0000, 4'b0000, 3'd0, 1'b0, "single_idle");

        // Maximum length on requester 1, len changed to 2 mid-run (pointer 3).
        cyc(0, 4'b0010, 12'h038, 4'b0010, 4'b0000, 3'd0, 1'b1, "max_c0");
        for (int i = 1; i <= 7; i++)
            cyc(0, 4'b0010, 12'h010, 4'b0010, 4'b0000, 3'(i), 1'b1, "max_run");
        cyc(0, 4'b0010, 12'h010, 4'b0000, 4'b0010, 3'd7, 1'b1, "max_done");
        cyc(0, 4'b0000, 12'h010, 4'b0000, 4'b0000, 3'd0, 1'b0, "max_idle");
        cyc(0, 4'b0010, 12'h010, 4'b0010, 4'b0000, 3'd0, 1'b1, "max2_c0");
        cyc(0, 4'b0010, 12'h010, 4'b0010, 4'b0000, 3'd1, 1'b1, "max2_c1");
        cyc(0, 4'b0010, 12'h010, 4'b0010, 4'b0000, 3'd2, 1'b1, "max2_c2");
        cyc(0, 4'b0010, 12'h010, 4'b0000, 4'b0010, 3'd2, 1'b1, "max2_done");
        cyc(0, 4'b0000, 12'h000, 4'b0000, 4'b0000, 3'd0, 1'b0, "max2_idle");

        // Reset mid-run of requester 1 (pointer 2 after grant), then 0110
        // must pick requester 1 because the pointer returned to 0.
        cyc(0, 4'b0010, 12'h028, 4'b0010, 4'b0000, 3'd0, 1'b1, "mrst_c0");
        cyc(0, 4'b0010, 12'h028, 4'b0010, 4'b0000, 3'd1, 1'b1, "mrst_c1");
        cyc(0, 4'b0010, 12'h028, 4'b0010, 4'b0000, 3'd2, 1'b1, "mrst_c2");
        cyc(1, 4'b0010, 12'h028, 4'b0000, 4'b0000, 3'd0, 1'b0, "mrst_reset");
        cyc(0, 4'b0000, 12'h028, 4'b0000, 4'b0000, 3'd0, 1'b0, "mrst_nodone");
        cyc(0, 4'b0110, 12'h000, 4'b0010, 4'b0000, 3'd0, 1'b1, "mrst_ptr0");
        cyc(0, 4'b0110, 12'h000, 4'b0000, 4'b0010, 3'd0, 1'b1, "mrst_done");
        cyc(0, 4'b0000, 12'h000, 4'b0000, 4'b0000, 3'd0, 1'b0, "mrst_idle");

        // Requester 3, len=5, drops req at count=1 (pointer 2 -> 0 on grant).
        cyc(0, 4'b1000, 12'hA00, 4'b1000, 4'b0000, 3'd0, 1'b1, "ab_c0");
        cyc(0, 4'b1000, 12'hA00, 4'b1000, 4'b0000, 3'd1, 1'b1, "ab_c1");
`ifdef COUNT_ARB_ABORT_EN
        cyc(0, 4'b0000, 12'hA00, 4'b0000, 4'b0000, 3'd0, 1'b0, "ab_abort");
        cyc(0, 4'b0000, 12'hA00, 4'b0000, 4'b0000, 3'd0, 1'b0, "ab_nodone");
`else
        for (int i = 2; i <= 5; i++)
            cyc(0, 4'b0000, 12'hA00, 4'b1000, 4'b0000, 3'(i), 1'b1, "ab_run");
        cyc(0, 4'b0000, 12'hA00, 4'b0000, 4'b1000, 3'd5, 1'b1, "ab_done");
        cyc(0, 4'b0000, 12'hA00, 4'b0000, 4'b0000, 3'd0, 1'b0, "ab_idle");
`endif
        // Pointer is 0 after granting requester 3: 1001 picks requester 0.
        cyc(0, 4'b1001, 12'h000, 4'b0001, 4'b0000, 3'd0, 1'b1, "ab_ptr_grant");
        cyc(0, 4'b1001, 12'h000, 4'b0000, 4'b0001, 3'd0, 1'b1, "ab_ptr_done");
        cyc(0, 4'b0000, 12'h000, 4'b0000, 4'b0000, 3'd0, 1'b0, "ab_ptr_idle");

        // Let the monitor drain the queue, bounded.
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        #3;
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/count_arbiter.md
Name: count_arbiter

Overview:
- Round-robin scheduler that shares one up-counter among NUM_REQ requesters.
- Each requester asks for a run of len+1 count cycles.
- The arbiter grants one requester at a time, latches its length, and runs the shared counter from 0 to that length.
- It pulses a per-requester done when the run finishes. The block sits between the requesting control blocks and the counter datapath.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
CNT_W, 3, counter and length width in bits

Ports:
clk    input   1                 clock; all logic rising-edge
rst    input   1                 reset, synchronous, active-high
req    input   NUM_REQ           per-requester request, level
len    input   NUM_REQ*CNT_W     packed lengths; requester i uses bits [i*CNT_W +: CNT_W]
grant  output  NUM_REQ           one-hot grant, registered; all-zero when no owner
count  output  CNT_W             shared counter value, registered
busy   output  1                 high whenever state != IDLE
done   output  NUM_REQ           one-hot single-cycle completion pulse, registered

Behaviour:
- Reset: rst is synchronous and active-high; clock is clk. On an edge with rst=1:
  - state=IDLE
  - grant=0, done=0, count=0, busy=0
  - round-robin pointer=0 (requester 0 highest priority)
  - rst dominates all other inputs.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - count=0, grant=0.
  - If req!=0 at an edge, select the winner: first set req bit scanning from the pointer upward, modulo NUM_REQ.
  - Register grant=onehot(winner), len_q=len[winner], count=0, state=RUN.
  - Pointer becomes (winner+1) mod NUM_REQ.
  - If req==0, stay in IDLE.
- RUN:
  - If count!=len_q: count=count+1 each edge.
  - If count==len_q at an edge: state=DONE, done=grant, grant=0; count holds len_q.
  - RUN therefore lasts len_q+1 cycles, showing count values 0..len_q.
- DONE:
  - Exactly one cycle: done asserted, grant=0, count=len_q.
  - Next edge: done=0, count=0, state=IDLE.
- Latency: req sampled in IDLE, grant visible the following cycle.
  - Minimum occupancy per run is len_q+3 cycles (RUN + DONE + one IDLE arbitration cycle).
  - Back-to-back grants are separated by at least one IDLE cycle with grant=0.
- len is latched only at grant. Changes to len during RUN/DONE have no effect.
- req changes of non-granted requesters during RUN/DONE are ignored until the next IDLE.
- Width and wrap:
  - len_q=2^CNT_W-1 counts to the maximum value with no wrap inside a run.
  - count never exceeds len_q.
  - len_q=0 gives a single RUN cycle at count=0.
- A requester still holding req after its done is re-eligible, but at lowest priority (pointer has moved past it).
- Invariants: at most one grant bit set; at most one done bit set; grant and done never both nonzero in the same cycle.
- Reset mid-run: no done pulse is generated; all outputs and the pointer return to reset values on that edge.

Optional Feature:
- Macro: COUNT_ARB_ABORT_EN.
- Defined: if the granted requester's req is 0 at an edge while in RUN:
  - state=IDLE, grant=0, count=0; no done pulse.
  - Pointer keeps its post-grant value.
  - Abort takes priority over the count==len_q terminal check on the same edge.
- Not defined: req of the granted requester is ignored during RUN; the run always completes with a done pulse.

Test Plan:
1. Reset: rst=1 for 2 edges with req=4'b1111 -> grant=0, done=0, count=0, busy=0; first grant after release is 4'b0001.
2. Single request: req=4'b0100, len[2]=3 -> grant=4'b0100 next cycle; count 0,1,2,3 over 4 cycles; then done=4'b0100 for 1 cycle with grant=0; count=0 and busy=0 the cycle after.
3. Round-robin: req=4'b1111 held, all len=0 -> grant sequence 0001,0010,0100,1000,0001; each grant lasts 1 cycle, separated by DONE and IDLE cycles.
4. Maximum length: len[1]=7, req=4'b0010; change len[1] to 2 mid-run -> count reaches 7 with no wrap; done=4'b0010 after count=7; next run starts at count=0.
5. Reset mid-run: rst=1 when count=2 -> next cycle grant=0, count=0, busy=0; no done pulse ever; pointer back to 0.
6. Abort (COUNT_ARB_ABORT_EN defined): drop req[3] at count=1 of len=5 -> grant=0, count=0, no done. Without the macro, the same stimulus completes to count=5 with done=4'b1000.
